// File: rtl/sram_arbiter_pkg.sv
// Shared SRAM arbiter defaults and FSM encoding, also used by the fetcher and execution units.
package sram_arbiter_pkg;

  localparam int SRAM_ADDR_SIZE_DEF = 15;
  localparam int DATA_SIZE_DEF      = 8;
  localparam int WAIT_STATES_DEF    = 2;
  localparam int WAIT_CNT_W         = 3;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_ACCESS = 2'd1;
  localparam logic [1:0] ST_DONE   = 2'd2;

  localparam logic GRANT_IF = 1'b0;
  localparam logic GRANT_EX = 1'b1;

  // Round-robin pick: a sole requester wins; on contention the port not served last wins.
  function automatic logic arb_pick_ex(input logic if_req, input logic ex_req,
                                       input logic last_grant);
    if (if_req && ex_req) return (last_grant == GRANT_IF);
    return ex_req;
  endfunction

endpackage

// File: rtl/sram_arbiter.sv
// Two-port round-robin arbiter (fetcher read, execution read/write) onto one async SRAM.
// Latency: WAIT_STATES+2 cycles from the sampling IDLE cycle to ack; one access per WAIT_STATES+3 cycles.
// Backpressure: requests are held until ack; the losing requester simply waits for the next grant.
module sram_arbiter
  import sram_arbiter_pkg::*;
#(
  parameter int SRAM_ADDR_SIZE = SRAM_ADDR_SIZE_DEF,
  parameter int DATA_SIZE      = DATA_SIZE_DEF,
  parameter int WAIT_STATES    = WAIT_STATES_DEF
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [SRAM_ADDR_SIZE-1:0] if_addr,
  input  logic                      if_rd_en,
  output logic [DATA_SIZE-1:0]      if_d_out,
  output logic                      if_ack,
  input  logic [SRAM_ADDR_SIZE-1:0] ex_addr,
  input  logic                      ex_rd_en,
  input  logic                      ex_wr_en,
  input  logic [DATA_SIZE-1:0]      ex_wr_data,
  output logic [DATA_SIZE-1:0]      ex_d_out,
  output logic                      ex_ack,
  output logic [SRAM_ADDR_SIZE-1:0] sram_addr,
  output logic [DATA_SIZE-1:0]      sram_wr_data,
  input  logic [DATA_SIZE-1:0]      sram_rd_data,
  output logic                      sram_ce_n,
  output logic                      sram_oe_n,
  output logic                      sram_we_n,
  output logic                      busy
);

  localparam logic [WAIT_CNT_W-1:0] WAIT_LOAD = WAIT_CNT_W'(WAIT_STATES);

  logic [1:0]            state;
  logic [WAIT_CNT_W-1:0] wait_cnt;
  logic                  grant;
  logic                  grant_wr;
  logic                  last_grant;
  logic                  ex_req;
  logic                  pick_ex;
  logic                  pick_wr;

  // A simultaneous read+write from the execution stage is a write.
  assign ex_req  = ex_rd_en | ex_wr_en;
  assign pick_ex = arb_pick_ex(if_rd_en, ex_req, last_grant);
  assign pick_wr = pick_ex & ex_wr_en;
  assign busy    = (state != ST_IDLE);

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= ST_IDLE;
      wait_cnt     <= '0;
      grant        <= GRANT_IF;
      grant_wr     <= 1'b0;
      last_grant   <= GRANT_EX;
      sram_addr    <= '0;
      sram_wr_data <= '0;
      sram_ce_n    <= 1'b1;
      sram_oe_n    <= 1'b1;
      sram_we_n    <= 1'b1;
      if_ack       <= 1'b0;
      ex_ack       <= 1'b0;
      if_d_out     <= '0;
      ex_d_out     <= '0;
    end else begin
      if_ack <= 1'b0;
      ex_ack <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (if_rd_en || ex_req) begin
            state     <= ST_ACCESS;
            grant     <= pick_ex ? GRANT_EX : GRANT_IF;
            grant_wr  <= pick_wr;
            sram_addr <= pick_ex ? ex_addr : if_addr;
            if (pick_wr) sram_wr_data <= ex_wr_data;
            wait_cnt  <= WAIT_LOAD;
            sram_ce_n <= 1'b0;
            sram_oe_n <= pick_wr;
            sram_we_n <= ~pick_wr;
          end
        end
        ST_ACCESS: begin
          if (wait_cnt == '0) begin
            // Last access cycle: sample read data and raise the ack for the DONE cycle.
            state     <= ST_DONE;
            sram_ce_n <= 1'b1;
            sram_oe_n <= 1'b1;
            sram_we_n <= 1'b1;
            if (!grant_wr) begin
              if (grant == GRANT_EX) ex_d_out <= sram_rd_data;
              else                   if_d_out <= sram_rd_data;
            end
            if_ack <= (grant == GRANT_IF);
            ex_ack <= (grant == GRANT_EX);
          end else begin
            wait_cnt <= wait_cnt - 1'b1;
          end
        end
        ST_DONE: begin
          state      <= ST_IDLE;
          last_grant <= grant;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sram_arbiter.sv
// Bench for sram_arbiter: WAIT_STATES=2 and WAIT_STATES=0 instances share request inputs, each with its own SRAM model.
module tb_sram_arbiter;
  import sram_arbiter_pkg::*;

  localparam int AW = 15;
  localparam int DW = 8;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic [AW-1:0] if_addr = '0, ex_addr = '0;
  logic          if_rd_en = 1'b0, ex_rd_en = 1'b0, ex_wr_en = 1'b0;
  logic [DW-1:0] ex_wr_data = '0;

  logic [DW-1:0] if_d_out2, ex_d_out2, sram_wr_data2, sram_rd_data2;
  logic [AW-1:0] sram_addr2;
  logic          if_ack2, ex_ack2, ce_n2, oe_n2, we_n2, busy2;
  logic [DW-1:0] if_d_out0, ex_d_out0, sram_wr_data0, sram_rd_data0;
  logic [AW-1:0] sram_addr0;
  logic          if_ack0, ex_ack0, ce_n0, oe_n0, we_n0, busy0;

  logic [DW-1:0] mem2 [0:(1<<AW)-1];
  logic [DW-1:0] mem0 [0:(1<<AW)-1];

  sram_arbiter #(.SRAM_ADDR_SIZE(AW), .DATA_SIZE(DW), .WAIT_STATES(2)) dut2 (
    .clk(clk), .reset(reset),
    .if_addr(if_addr), .if_rd_en(if_rd_en), .if_d_out(if_d_out2), .if_ack(if_ack2),
    .ex_addr(ex_addr), .ex_rd_en(ex_rd_en), .ex_wr_en(ex_wr_en), .ex_wr_data(ex_wr_data),
    .ex_d_out(ex_d_out2), .ex_ack(ex_ack2),
    .sram_addr(sram_addr2), .sram_wr_data(sram_wr_data2), .sram_rd_data(sram_rd_data2),
    .sram_ce_n(ce_n2), .sram_oe_n(oe_n2), .sram_we_n(we_n2), .busy(busy2)
  );

  sram_arbiter #(.SRAM_ADDR_SIZE(AW), .DATA_SIZE(DW), .WAIT_STATES(0)) dut0 (
    .clk(clk), .reset(reset),
    .if_addr(if_addr), .if_rd_en(if_rd_en), .if_d_out(if_d_out0), .if_ack(if_ack0),
    .ex_addr(ex_addr), .ex_rd_en(ex_rd_en), .ex_wr_en(ex_wr_en), .ex_wr_data(ex_wr_data),
    .ex_d_out(ex_d_out0), .ex_ack(ex_ack0),
    .sram_addr(sram_addr0), .sram_wr_data(sram_wr_data0), .sram_rd_data(sram_rd_data0),
    .sram_ce_n(ce_n0), .sram_oe_n(oe_n0), .sram_we_n(we_n0), .busy(busy0)
  );

  // Asynchronous SRAM models: combinational read, write while ce_n and we_n are low.
  assign sram_rd_data2 = mem2[sram_addr2];
  assign sram_rd_data0 = mem0[sram_addr0];
  always @(posedge clk) if (!ce_n2 && !we_n2) mem2[sram_addr2] <= sram_wr_data2;
  always @(posedge clk) if (!ce_n0 && !we_n0) mem0[sram_addr0] <= sram_wr_data0;

  // View of whichever instance is under test.
  bit sel = 1'b0;
  logic [DW-1:0] m_if_d_out, m_ex_d_out, m_sram_wr_data;
  logic [AW-1:0] m_sram_addr;
  logic          m_if_ack, m_ex_ack, m_ce_n, m_oe_n, m_we_n, m_busy;
  always_comb begin
    m_if_d_out     = sel ? if_d_out0     : if_d_out2;
    m_ex_d_out     = sel ? ex_d_out0     : ex_d_out2;
    m_sram_wr_data = sel ? sram_wr_data0 : sram_wr_data2;
    m_sram_addr    = sel ? sram_addr0    : sram_addr2;
    m_if_ack       = sel ? if_ack0       : if_ack2;
    m_ex_ack       = sel ? ex_ack0       : ex_ack2;
    m_ce_n         = sel ? ce_n0         : ce_n2;
    m_oe_n         = sel ? oe_n0         : oe_n2;
    m_we_n         = sel ? we_n0         : we_n2;
    m_busy         = sel ? busy0         : busy2;
  end

  typedef struct {
    bit            sel;
    bit            ex;
    bit            rd;
    bit            wr;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [DW-1:0] exp;
  } vec_t;

  typedef struct {
    bit            ex;
    logic [DW-1:0] data;
  } sb_t;

  vec_t vecs[$];
  sb_t  sb[$];
  int   n_checks = 0;
  int   n_fail = 0;

  function automatic logic [DW-1:0] init_val(input logic [AW-1:0] a);
    return a[7:0] ^ {1'b0, a[14:8]};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic pop_check(input bit ex, input logic [DW-1:0] dout);
    sb_t it;
    if (sb.size() == 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL unexpected_ack: got ack on port ex=%0d, expected no ack", ex);
      return;
    end
    it = sb.pop_front();
    check("ack_port", 32'(ex), 32'(it.ex));
    check("ack_data", 32'(dout), 32'(it.data));
  endtask

  task automatic handle_acks();
    if (m_if_ack) pop_check(1'b0, m_if_d_out);
    if (m_ex_ack) pop_check(1'b1, m_ex_d_out);
  endtask

  task automatic drop_reqs();
    if_rd_en = 1'b0;
    ex_rd_en = 1'b0;
    ex_wr_en = 1'b0;
  endtask

  task automatic reset_pulse();
    @(negedge clk);
    reset = 1'b1;
    drop_reqs();
    repeat (2) @(negedge clk);
    reset = 1'b0;
    sb.delete();
  endtask

  task automatic timeout_fail(input string name, input int limit);
    n_checks++;
    n_fail++;
    $display("FAIL %s: got no ack within %0d cycles, expected ack", name, limit);
  endtask

  task automatic run_vec(input vec_t v);
    int ws = sel ? 0 : 2;
    int cyc = 0, lat = -1, ce_cnt = 0, oe_cnt = 0, we_cnt = 0, extra = 0;
    logic [DW-1:0] wd_seen = '0, own_before, other_before, mem_after;
    logic [AW-1:0] addr_at_ack = '0;
    @(negedge clk);
    own_before   = v.ex ? m_ex_d_out : m_if_d_out;
    other_before = v.ex ? m_if_d_out : m_ex_d_out;
    if (v.ex) begin
      ex_addr = v.addr; ex_rd_en = v.rd; ex_wr_en = v.wr; ex_wr_data = v.wdata;
    end else begin
      if_addr = v.addr; if_rd_en = 1'b1;
    end
    sb.push_back('{ex: v.ex, data: (v.wr ? own_before : v.exp)});
    while (lat < 0 && cyc < 40) begin
      @(negedge clk);
      cyc++;
      if (!m_ce_n) ce_cnt++;
      if (!m_oe_n) oe_cnt++;
      if (!m_we_n) begin we_cnt++; wd_seen = m_sram_wr_data; end
      if (v.ex ? m_ex_ack : m_if_ack) begin
        lat = cyc;
        addr_at_ack = m_sram_addr;
        drop_reqs();
      end
      handle_acks();
    end
    if (lat < 0) begin
      timeout_fail("vec_ack", 40);
      drop_reqs();
    end
    repeat (4) begin
      @(negedge clk);
      if (m_if_ack || m_ex_ack) extra++;
      handle_acks();
    end
    check("latency", 32'(lat), 32'(ws + 2));
    check("ce_low_cycles", 32'(ce_cnt), 32'(ws + 1));
    check("oe_low_cycles", 32'(oe_cnt), v.wr ? 32'd0 : 32'(ws + 1));
    check("we_low_cycles", 32'(we_cnt), v.wr ? 32'(ws + 1) : 32'd0);
    check("extra_acks", 32'(extra), 32'd0);
    check("addr_held_at_ack", 32'(addr_at_ack), 32'(v.addr));
    check("busy_after", 32'(m_busy), 32'd0);
    check("other_dout_held", 32'(v.ex ? m_if_d_out : m_ex_d_out), 32'(other_before));
    if (v.wr) begin
      mem_after = sel ? mem0[v.addr] : mem2[v.addr];
      check("sram_wr_data", 32'(wd_seen), 32'(v.wdata));
      check("mem_written", 32'(mem_after), 32'(v.exp));
    end
  endtask

  initial begin
    int t[3];
    int n_ack, cyc;

    for (int a = 0; a < (1 << AW); a++) begin
      mem2[a] = init_val(AW'(a));
      mem0[a] = init_val(AW'(a));
    end
    mem2[15'h1234] = 8'hA5;
    mem0[15'h1234] = 8'hA5;

    vecs.push_back('{sel: 0, ex: 0, rd: 1, wr: 0, addr: 15'h1234, wdata: 8'h00, exp: 8'hA5});
    vecs.push_back('{sel: 0, ex: 1, rd: 0, wr: 1, addr: 15'h7001, wdata: 8'h3C, exp: 8'h3C});
    vecs.push_back('{sel: 0, ex: 1, rd: 1, wr: 0, addr: 15'h7001, wdata: 8'h00, exp: 8'h3C});
    vecs.push_back('{sel: 0, ex: 1, rd: 1, wr: 1, addr: 15'h0456, wdata: 8'hFF, exp: 8'hFF});
    vecs.push_back('{sel: 0, ex: 0, rd: 1, wr: 0, addr: 15'h0456, wdata: 8'h00, exp: 8'hFF});
    vecs.push_back('{sel: 0, ex: 1, rd: 1, wr: 0, addr: 15'h4321, wdata: 8'h00, exp: init_val(15'h4321)});
    vecs.push_back('{sel: 1, ex: 0, rd: 1, wr: 0, addr: 15'h1234, wdata: 8'h00, exp: 8'hA5});
    vecs.push_back('{sel: 1, ex: 1, rd: 0, wr: 1, addr: 15'h2222, wdata: 8'h5A, exp: 8'h5A});
    vecs.push_back('{sel: 1, ex: 1, rd: 1, wr: 0, addr: 15'h2222, wdata: 8'h00, exp: 8'h5A});

    // Reset values.
    repeat (3) @(negedge clk);
    check("rst_if_ack", 32'(if_ack2), 32'd0);
    check("rst_ex_ack", 32'(ex_ack2), 32'd0);
    check("rst_busy", 32'(busy2), 32'd0);
    check("rst_strobes", 32'({ce_n2, oe_n2, we_n2}), 32'h7);
    check("rst_sram_addr", 32'(sram_addr2), 32'd0);
    check("rst_sram_wr_data", 32'(sram_wr_data2), 32'd0);
    check("rst_d_out", 32'({if_d_out2, ex_d_out2}), 32'd0);
    reset = 1'b0;

    foreach (vecs[i]) begin
      if (vecs[i].sel != sel) begin
        sel = vecs[i].sel;
        reset_pulse();
      end
      run_vec(vecs[i]);
    end

    // Contention after reset: IF wins first, then alternation, 5 cycles apart.
    sel = 1'b0;
    reset_pulse();
    @(negedge clk);
    if_addr = 15'h1234; ex_addr = 15'h0300;
    if_rd_en = 1'b1; ex_rd_en = 1'b1;
    sb.push_back('{ex: 1'b0, data: 8'hA5});
    sb.push_back('{ex: 1'b1, data: init_val(15'h0300)});
    sb.push_back('{ex: 1'b0, data: 8'hA5});
    n_ack = 0; cyc = 0;
    while (n_ack < 3 && cyc < 60) begin
      @(negedge clk);
      cyc++;
      if (m_if_ack || m_ex_ack) begin
        t[n_ack] = cyc;
        n_ack++;
      end
      handle_acks();
    end
    drop_reqs();
    if (n_ack < 3) timeout_fail("contend_acks", 60);
    else begin
      check("contend_first_lat", 32'(t[0]), 32'd4);
      check("contend_gap1", 32'(t[1] - t[0]), 32'd5);
      check("contend_gap2", 32'(t[2] - t[1]), 32'd5);
    end
    repeat (6) begin @(negedge clk); handle_acks(); end
    check("contend_sb_empty", 32'(sb.size()), 32'd0);

    // Reset during the second ACCESS cycle of a read aborts it silently.
    @(negedge clk);
    if_addr = 15'h0456; if_rd_en = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("abort_in_access", 32'(m_ce_n), 32'd0);
    reset = 1'b1;
    if_rd_en = 1'b0;
    @(negedge clk);
    check("abort_strobes", 32'({m_ce_n, m_oe_n, m_we_n}), 32'h7);
    check("abort_busy", 32'(m_busy), 32'd0);
    check("abort_if_d_out", 32'(m_if_d_out), 32'd0);
    reset = 1'b0;
    n_ack = 0;
    repeat (6) begin
      @(negedge clk);
      if (m_if_ack || m_ex_ack) n_ack++;
    end
    check("abort_no_ack", 32'(n_ack), 32'd0);

    // Zero wait states: back-to-back reads every 3 cycles.
    sel = 1'b1;
    reset_pulse();
    @(negedge clk);
    if_addr = 15'h1234; if_rd_en = 1'b1;
    repeat (3) sb.push_back('{ex: 1'b0, data: 8'hA5});
    n_ack = 0; cyc = 0;
    while (n_ack < 3 && cyc < 40) begin
      @(negedge clk);
      cyc++;
      if (m_if_ack) begin
        t[n_ack] = cyc;
        n_ack++;
      end
      if (n_ack == 3) drop_reqs();
      handle_acks();
    end
    drop_reqs();
    if (n_ack < 3) timeout_fail("ws0_acks", 40);
    else begin
      check("ws0_first_lat", 32'(t[0]), 32'd2);
      check("ws0_gap1", 32'(t[1] - t[0]), 32'd3);
      check("ws0_gap2", 32'(t[2] - t[1]), 32'd3);
    end
    repeat (4) begin @(negedge clk); handle_acks(); end
    check("ws0_sb_empty", 32'(sb.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/sram_arbiter.md
SRAM_ARBITER -- requirements
Module: sram_arbiter

Interface
REQ-001 Parameter SRAM_ADDR_SIZE, default 15, meaning {channel[2:0], local address[11:0]}.
REQ-002 Parameter DATA_SIZE, default 8, meaning SRAM data width (one opcode/operand byte).
REQ-003 Parameter WAIT_STATES, default 2, meaning extra SRAM cycles per access; legal range 0..7.
REQ-004 clk  in  1  single clock; all activity on the positive edge.
REQ-005 reset  in  1  synchronous, active-high reset.
REQ-006 if_addr  in  SRAM_ADDR_SIZE  instruction fetcher read address.
REQ-007 if_rd_en  in  1  fetcher read request, held until if_ack.
REQ-008 if_d_out  out  DATA_SIZE  registered read data for the fetcher.
REQ-009 if_ack  out  1  one-cycle pulse; if_d_out is valid in this cycle.
REQ-010 ex_addr  in  SRAM_ADDR_SIZE  execution-stage data address.
REQ-011 ex_rd_en  in  1  execution read request, held until ex_ack.
REQ-012 ex_wr_en  in  1  execution write request, held until ex_ack.
REQ-013 ex_wr_data  in  DATA_SIZE  write data, held with ex_wr_en.
REQ-014 ex_d_out  out  DATA_SIZE  registered read data for the execution stage.
REQ-015 ex_ack  out  1  one-cycle completion pulse.
REQ-016 sram_addr  out  SRAM_ADDR_SIZE  registered SRAM address.
REQ-017 sram_wr_data  out  DATA_SIZE  registered SRAM write data.
REQ-018 sram_rd_data  in  DATA_SIZE  SRAM read data.
REQ-019 sram_ce_n, sram_oe_n, sram_we_n  out  1 each  active-low SRAM strobes.
REQ-020 busy  out  1  high whenever state is not IDLE.

Function
REQ-021 FSM states: IDLE, ACCESS, DONE.
REQ-022 IDLE: if any request is present, grant one, register sram_addr (and sram_wr_data for writes), load wait counter with WAIT_STATES, go to ACCESS; otherwise stay.
REQ-023 Arbitration is round-robin on a last_grant bit: a sole requester is granted; with both requesting, the port not served last is granted.
REQ-024 ex_wr_en and ex_rd_en both high is treated as a write; the read is ignored.
REQ-025 ACCESS lasts WAIT_STATES+1 cycles: sram_ce_n low throughout; sram_oe_n low for reads; sram_we_n low for writes.
REQ-026 Read data is captured from sram_rd_data on the last ACCESS cycle into the granted port's d_out register.
REQ-027 DONE lasts one cycle: strobes high, sram_addr held, granted port's ack high, last_grant updated, next state IDLE.
REQ-028 Latency is WAIT_STATES+2 cycles from the IDLE cycle that samples the request to ack; back-to-back throughput is one access per WAIT_STATES+3 cycles.
REQ-029 A request withdrawn mid-access still completes and is acked; the requester ignores the ack.
REQ-030 d_out registers hold their value until the next read on that port.
REQ-031 The non-granted requester waits with no ack; it is served no later than the next grant.

Reset
REQ-032 Reset forces IDLE from any state, including mid-ACCESS, and issues no ack for the aborted access.
REQ-033 Reset values: if_ack=0, ex_ack=0, busy=0, sram_ce_n=sram_oe_n=sram_we_n=1, sram_addr=0, sram_wr_data=0, if_d_out=0, ex_d_out=0.
REQ-034 Reset sets last_grant=EX, so the fetcher wins the first contended grant.

Structure
REQ-035 Shared package holds SRAM_ADDR_SIZE, DATA_SIZE, WAIT_STATES defaults and the state encoding, for common use with the fetcher and execution units.
REQ-036 Single flat module; no sub-module.

Verification
REQ-037 WAIT_STATES=2; if_rd_en with if_addr=15'h1234; SRAM returns 8'hA5 -> ce_n/oe_n low 3 cycles, if_ack 4 cycles after the sampling edge, if_d_out=8'hA5.
REQ-038 ex_wr_en, ex_addr=15'h7001, ex_wr_data=8'h3C -> we_n low 3 cycles, sram_wr_data=8'h3C, oe_n stays high, ex_ack pulse, no if_ack.
REQ-039 After reset, if_rd_en and ex_rd_en rise in the same cycle and stay high -> grants alternate IF, EX, IF, with 5 cycles between acks.
REQ-040 Reset asserted during the second ACCESS cycle of a read -> strobes high on the next cycle, state IDLE, no ack, d_out=0.
REQ-041 ex_rd_en and ex_wr_en both high with data 8'hFF -> write performed, oe_n never low, single ex_ack.
REQ-042 WAIT_STATES=0 -> one ACCESS cycle, ack 2 cycles after sampling, back-to-back reads every 3 cycles.
